debounce_multi: RTL and testbench

// - N-channel, counter-based debouncer for NexysA7 push-buttons and switches. It replaces the single-bit, 2-sample debounce.
// - Each channel: 2-FF synchroniser, then a stability counter. Output changes only after STABLE_CYCLES consecutive qualified samples disagree with it.
// - Per-channel rise/fall pulses drive the clock-setting FSM directly.
// - Optional tick input lets a shared prescaler stretch the debounce window to milliseconds.

---
 rtl/debounce_multi.sv | 123 ++++++++++++
 tb/tb_debounce_multi.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
// debounce_multi: N-channel counter-based debouncer with a 2-FF synchroniser
// per channel, registered rise/fall pulses and an optional long-press pulse.
//
// Ports:
//   clk  - system clock, all logic on the rising edge
//   rst  - synchronous, active-high reset
//   tick - sample qualifier (tie 1'b1 to count every clock)
//   d    - raw asynchronous inputs, one bit per channel
//   q    - debounced level, registered
//   rise - 1-cycle pulse in the cycle q[i] goes 0->1
//   fall - 1-cycle pulse in the cycle q[i] goes 1->0
//   long - 1-cycle long-press pulse
//
// Build option: define DEBOUNCE_LONGPRESS_EN to include the long-press
// counters. Without it, long is driven constant 0 and LONG_TICKS is unused.
module debounce_multi #(
    parameter int N_CH          = 4,
    parameter int STABLE_CYCLES = 16,
    parameter int LONG_TICKS    = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            tick,
    input  logic [N_CH-1:0] d,
    output logic [N_CH-1:0] q,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] long
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("STABLE_CYCLES must be >= 1");
    end

    if (LONG_TICKS < 1) begin : g_bad_long
        $error("LONG_TICKS must be >= 1");
    end

    logic [N_CH-1:0]  s1;
    logic [N_CH-1:0]  s2;
    logic [CNT_W-1:0] cnt [N_CH];

    // Two-stage synchroniser; only s2 is ever compared.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    // Stability counter. Any sample that agrees with q restarts the
    // window, so cnt stays below STABLE_CYCLES and never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= '0;
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            rise <= '0;
            fall <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (s2[i] == q[i]) begin
                    cnt[i] <= '0;
                end else if (tick) begin
                    if (cnt[i] == CNT_LAST) begin
                        q[i]    <= s2[i];
                        cnt[i]  <= '0;
                        rise[i] <= s2[i];
                        fall[i] <= ~s2[i];
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

`ifdef DEBOUNCE_LONGPRESS_EN
    localparam int LONG_W = $clog2(LONG_TICKS + 1);
    localparam logic [LONG_W-1:0] LONG_MAX =
        LONG_W'(LONG_TICKS);
    localparam logic [LONG_W-1:0] LONG_LAST =
        LONG_W'(LONG_TICKS - 1);

    logic [LONG_W-1:0] lcnt [N_CH];

    // lcnt saturates at LONG_TICKS so a held press fires only once;
    // releasing (q low) re-arms it.
    always_ff @(posedge clk) begin
        if (rst) begin
            long <= '0;
            for (int i = 0; i < N_CH; i++) begin
                lcnt[i] <= '0;
            end
        end else begin
            long <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (!q[i]) begin
                    lcnt[i] <= '0;
                end else if (tick && lcnt[i] < LONG_MAX) begin
                    lcnt[i] <= lcnt[i] + LONG_W'(1);
                    if (lcnt[i] == LONG_LAST) begin
                        long[i] <= 1'b1;
                    end
                end
            end
        end
    end
`else
    assign long = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// tb_debounce_multi: directed self-checking bench for debounce_multi
// (N_CH=4, STABLE_CYCLES=4, LONG_TICKS=8).
module tb_debounce_multi;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic [3:0] d;
    logic [3:0] q;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] long;

    int n_cmp = 0;
    int n_bad = 0;
    int rc [4];
    int fc [4];
    int lc [4];
    int q0_seen;

    debounce_multi #(
        .N_CH(4),
        .STABLE_CYCLES(4),
        .LONG_TICKS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tick(tick),
        .d(d),
        .q(q),
        .rise(rise),
        .fall(fall),
        .long(long)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        for (int i = 0; i < 4; i++) begin
            rc[i] = 0;
            fc[i] = 0;
            lc[i] = 0;
        end
    endtask

    // One rising edge, then sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            rc[i] += int'(rise[i]);
            fc[i] += int'(fall[i]);
            lc[i] += int'(long[i]);
        end
    endtask

    initial begin
        rst  = 1'b1;
        tick = 1'b1;
        d    = 4'hF;
        clr();

        // Reset held for two edges.
        step();
        step();
        chk("rst_q", 32'(q), 32'h0);
        chk("rst_rise", 32'(rise), 32'h0);
        chk("rst_fall", 32'(fall), 32'h0);
        chk("rst_long", 32'(long), 32'h0);

        // Release: q follows at the 6th edge.
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        chk("rel_q_e5", 32'(q), 32'h0);
        chk("rel_rise_e5", 32'(rc[0] + rc[1] + rc[2] + rc[3]), 32'd0);
        step();
        chk("rel_q_e6", 32'(q), 32'hF);
        chk("rel_rise_e6", 32'(rise), 32'hF);
        step();
        chk("rel_rise_e7", 32'(rise), 32'h0);

        // All channels back low.
        d = 4'h0;
        clr();
        for (int k = 1; k <= 6; k++) step();
        chk("low_q", 32'(q), 32'h0);
        chk("low_fall", 32'(fc[0] + fc[1] + fc[2] + fc[3]), 32'd4);
        step();

        // Bounce on d[0], then hold 1.
        clr();
        q0_seen = 0;
        for (int k = 0; k < 10; k++) begin
            d[0] = ~d[0];
            step();
            q0_seen += int'(q[0]);
        end
        d[0] = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            step();
            q0_seen += int'(q[0]);
        end
        chk("bnc_q0_low", 32'(q0_seen), 32'd0);
        step();
        chk("bnc_q0_e6", 32'(q[0]), 32'h1);
        for (int k = 0; k < 4; k++) step();
        chk("bnc_rise0", 32'(rc[0]), 32'd1);
        chk("bnc_fall0", 32'(fc[0]), 32'd0);

        // Glitch: q[1] high, then a 3-clock low glitch.
        d[1] = 1'b1;
        for (int k = 1; k <= 6; k++) step();
        chk("gl_q1_up", 32'(q[1]), 32'h1);
        clr();
        d[1] = 1'b0;
        for (int k = 0; k < 3; k++) step();
        d[1] = 1'b1;
        for (int k = 0; k < 8; k++) step();
        chk("gl_q1_held", 32'(q[1]), 32'h1);
        chk("gl_fall1", 32'(fc[1]), 32'd0);

        // Tick gating: 4th qualified sample at edge 15.
        clr();
        d[2] = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick = (k % 4 == 3);
            step();
            if (k == 14) chk("tk_q2_e14", 32'(q[2]), 32'h0);
            if (k == 15) begin
                chk("tk_q2_e15", 32'(q[2]), 32'h1);
                chk("tk_rise", 32'(rise), 32'h4);
            end
        end
        tick = 1'b1;
        step();
        chk("tk_rise2_once", 32'(rc[2]), 32'd1);

        // Mid-count reset on channel 3.
        clr();
        d[3] = 1'b1;
        for (int k = 1; k <= 3; k++) step();
        rst = 1'b1;
        step();
        chk("mr_q", 32'(q), 32'h0);
        chk("mr_rise", 32'(rise), 32'h0);
        rst = 1'b0;
        clr();
        for (int k = 1; k <= 5; k++) step();
        chk("mr_q_e5", 32'(q), 32'h0);
        chk("mr_rise3_e5", 32'(rc[3]), 32'd0);
        step();
        chk("mr_q_e6", 32'(q), 32'hF);
        chk("mr_rise_e6", 32'(rise), 32'hF);

        // Long press: q high since edge 6, lcnt reaches 8 at edge 14.
        for (int k = 7; k <= 20; k++) begin
            step();
`ifdef DEBOUNCE_LONGPRESS_EN
            if (k == 13) chk("lp_e13", 32'(long), 32'h0);
            if (k == 14) chk("lp_e14", 32'(long), 32'hF);
            if (k == 15) chk("lp_e15", 32'(long), 32'h0);
`else
            if (k == 14) chk("lp_off_e14", 32'(long), 32'h0);
`endif
        end
`ifdef DEBOUNCE_LONGPRESS_EN
        chk("lp_once", 32'(lc[0]), 32'd1);
`else
        chk("lp_off_none", 32'(lc[0] + lc[1] + lc[2] + lc[3]),
            32'd0);
`endif
        chk("lp_q_held", 32'(q), 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
